// File: rtl/dmem_responder_if.sv
// dmem_itf: word-addressed, byte-masked data-memory request/response bus.
// The master drives requests; the responder returns one resp pulse per request.
interface dmem_itf;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport mst (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slv (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/dmem_responder.sv
// In-order data-memory responder: byte-masked word array behind a fixed-latency
// response FIFO with response backpressure and a sticky error flag.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 8
) (
  input  logic  clk,
  input  logic  rst,
  dmem_itf.slv  slv_itf,
  input  logic  stall_i,
  output logic  err_o
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AGE_W = $clog2(LATENCY + 1);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem_q      [MEM_WORDS];
  logic [31:0]      ent_data_q [DEPTH];
  logic [AGE_W-1:0] ent_age_q  [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             stall_q, err_q, err_d;

  logic             req, is_wr, illegal, full, pop, push, drop;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, push_data;
  logic             unused_addr;

  assign unused_addr = ^{slv_itf.addr[31:IDX_W+2], slv_itf.addr[1:0]};

  always_comb begin
    req     = (|slv_itf.rmask) || (|slv_itf.wmask);
    is_wr   = |slv_itf.wmask;
    illegal = (|slv_itf.rmask) && (|slv_itf.wmask);
    idx     = slv_itf.addr[IDX_W+1:2];
    rd_word = mem_q[idx];
    // A request with any write byte is a write; its response carries no data.
    push_data = '0;
    if (!is_wr) begin
      for (int i = 0; i < 4; i++) begin
        push_data[8*i +: 8] = slv_itf.rmask[i] ? rd_word[8*i +: 8] : 8'h00;
      end
    end
    pop  = (count_q != '0) && (ent_age_q[rptr_q] == AGE_MAX) && !stall_q;
    full = (count_q == CNT_FULL);
    drop = req && full && !pop;
    push = req && !drop;

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q || illegal || drop;

    slv_itf.resp  = pop;
    slv_itf.rdata = pop ? ent_data_q[rptr_q] : 32'h0;
  end

  assign err_o = err_q;

  // Array contents survive reset; only a request outside reset may write.
  always_ff @(posedge clk) begin
    if (!rst && push && is_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (slv_itf.wmask[i]) mem_q[idx][8*i +: 8] <= slv_itf.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_age_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      stall_q <= stall_i;
      err_q   <= err_d;
      // A fresh entry reads age 1 in the cycle after acceptance.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wptr_q == PTR_W'(i))) begin
          ent_age_q[i]  <= AGE_ONE;
          ent_data_q[i] <= push_data;
        end else if (ent_age_q[i] != AGE_MAX) begin
          ent_age_q[i] <= ent_age_q[i] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses defaults (LATENCY=2, DEPTH=8),
// instance B uses DEPTH=4, LATENCY=4 for the full-queue case.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rsta = 1'b1;
  logic rstb = 1'b1;
  logic stall_a = 1'b0;
  logic stall_b = 1'b0;
  logic err_a, err_b;
  int   checks = 0;
  int   failures = 0;

  dmem_itf itf_a ();
  dmem_itf itf_b ();

  dmem_responder u_dut_a (
    .clk(clk), .rst(rsta), .slv_itf(itf_a), .stall_i(stall_a), .err_o(err_a)
  );

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(4), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rstb), .slv_itf(itf_b), .stall_i(stall_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    itf_a.addr = '0; itf_a.rmask = '0; itf_a.wmask = '0; itf_a.wdata = '0;
    itf_b.addr = '0; itf_b.rmask = '0; itf_b.wmask = '0; itf_b.wdata = '0;
  end

  // Sample outputs of the cycle that is starting, then apply that cycle's inputs.
  task automatic tick_a(input logic rs, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd, input logic st,
                        output logic r, output logic [31:0] d, output logic e);
    @(negedge clk);
    r = itf_a.resp; d = itf_a.rdata; e = err_a;
    rsta = rs; itf_a.addr = a; itf_a.rmask = rm; itf_a.wmask = wm; itf_a.wdata = wd;
    stall_a = st;
  endtask

  task automatic tick_b(input logic rs, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd, input logic st,
                        output logic r, output logic [31:0] d, output logic e);
    @(negedge clk);
    r = itf_b.resp; d = itf_b.rdata; e = err_b;
    rstb = rs; itf_b.addr = a; itf_b.rmask = rm; itf_b.wmask = wm; itf_b.wdata = wd;
    stall_b = st;
  endtask

  task automatic idle_a(input int n);
    logic r; logic [31:0] d; logic e;
    for (int i = 0; i < n; i++) tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rsta = 1'b0; rstb = 1'b0;
    @(negedge clk);
    checks++;
    if (itf_a.resp !== 1'b0 || itf_a.rdata !== 32'h0 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a resp=%b rdata=%h err=%b exp 0/0/0", itf_a.resp, itf_a.rdata, err_a);
    end
    checks++;
    if (itf_b.resp !== 1'b0 || itf_b.rdata !== 32'h0 || err_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b resp=%b rdata=%h err=%b exp 0/0/0", itf_b.resp, itf_b.rdata, err_b);
    end
  endtask

  task automatic test_basic;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      tick_a(1'b0, 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, r, d, e);
      else if (c == 3) tick_a(1'b0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0, r, d, e);
      else             tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c == 2 || c == 5);
      ed = (c == 5) ? 32'hDEADBEEF : 32'h0;
      checks++;
      if (r !== er || d !== ed) begin
        failures++;
        $display("FAIL basic c=%0d resp=%b rdata=%h exp resp=%b rdata=%h", c, r, d, er, ed);
      end
    end
    idle_a(2);
  endtask

  task automatic test_bytemask;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed;
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      tick_a(1'b0, 32'h20, 4'h0, 4'hF, 32'h11223344, 1'b0, r, d, e);
      else if (c == 1) tick_a(1'b0, 32'h1020, 4'h0, 4'h2, 32'hAABBCCDD, 1'b0, r, d, e);
      else if (c == 2) tick_a(1'b0, 32'h23, 4'h6, 4'h0, 32'h0, 1'b0, r, d, e);
      else             tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c >= 2 && c <= 4);
      ed = (c == 4) ? 32'h0022CC00 : 32'h0;
      checks++;
      if (r !== er || d !== ed) begin
        failures++;
        $display("FAIL bytemask c=%0d resp=%b rdata=%h exp resp=%b rdata=%h", c, r, d, er, ed);
      end
    end
    idle_a(2);
  endtask

  task automatic test_back_to_back;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) tick_a(1'b0, 32'h100 + 32'(4*c), 4'h0, 4'hF, 32'hA0000000 + 32'(c), 1'b0, r, d, e);
      else       tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c >= 2 && c <= 9);
      checks++;
      if (r !== er || d !== 32'h0) begin
        failures++;
        $display("FAIL b2b_wr c=%0d resp=%b rdata=%h exp resp=%b rdata=0", c, r, d, er);
      end
    end
    idle_a(2);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) tick_a(1'b0, 32'h100 + 32'(4*c), 4'hF, 4'h0, 32'h0, 1'b0, r, d, e);
      else       tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c >= 2 && c <= 9);
      ed = er ? 32'hA0000000 + 32'(c - 2) : 32'h0;
      checks++;
      if (r !== er || d !== ed) begin
        failures++;
        $display("FAIL b2b_rd c=%0d resp=%b rdata=%h exp resp=%b rdata=%h", c, r, d, er, ed);
      end
    end
    idle_a(2);
  endtask

  task automatic test_stall;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed; logic st;
    for (int c = 0; c < 13; c++) begin
      st = (c >= 1 && c <= 5);
      if (c < 4) tick_a(1'b0, 32'h100 + 32'(4*c), 4'hF, 4'h0, 32'h0, st, r, d, e);
      else       tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, st, r, d, e);
      er = (c >= 7 && c <= 10);
      ed = er ? 32'hA0000000 + 32'(c - 7) : 32'h0;
      checks++;
      if (r !== er || d !== ed) begin
        failures++;
        $display("FAIL stall c=%0d resp=%b rdata=%h exp resp=%b rdata=%h", c, r, d, er, ed);
      end
    end
    checks++;
    if (err_a !== 1'b0) begin
      failures++;
      $display("FAIL stall_err err=%b exp 0", err_a);
    end
    idle_a(2);
  endtask

  task automatic test_illegal;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed; logic ee;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      tick_a(1'b0, 32'h30, 4'hF, 4'hF, 32'h55AA55AA, 1'b0, r, d, e);
      else if (c == 3) tick_a(1'b0, 32'h30, 4'hF, 4'h0, 32'h0, 1'b0, r, d, e);
      else             tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c == 2 || c == 5);
      ed = (c == 5) ? 32'h55AA55AA : 32'h0;
      ee = (c >= 1);
      checks++;
      if (r !== er || d !== ed || e !== ee) begin
        failures++;
        $display("FAIL illegal c=%0d resp=%b rdata=%h err=%b exp resp=%b rdata=%h err=%b",
                 c, r, d, e, er, ed, ee);
      end
    end
    idle_a(2);
  endtask

  task automatic test_reset_midburst;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed;
    for (int c = 0; c < 14; c++) begin
      if (c < 3)        tick_a(1'b0, 32'h100 + 32'(4*c), 4'hF, 4'h0, 32'h0, 1'b1, r, d, e);
      else if (c == 3)  tick_a(1'b1, 32'h10, 4'h0, 4'hF, 32'h12345678, 1'b1, r, d, e);
      else if (c == 10) tick_a(1'b0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0, r, d, e);
      else              tick_a(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
      er = (c == 12);
      ed = (c == 12) ? 32'hDEADBEEF : 32'h0;
      checks++;
      if (r !== er || d !== ed) begin
        failures++;
        $display("FAIL rst_mid c=%0d resp=%b rdata=%h exp resp=%b rdata=%h", c, r, d, er, ed);
      end
      if (c >= 4) begin
        checks++;
        if (e !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_err c=%0d err=%b exp 0", c, e);
        end
      end
    end
  endtask

  task automatic test_full;
    logic r; logic [31:0] d; logic e; logic er; logic [31:0] ed; logic ee; logic st;
    tick_b(1'b0, 32'h40, 4'h0, 4'hF, 32'h0000600D, 1'b0, r, d, e);
    for (int i = 0; i < 6; i++) tick_b(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
    for (int c = 0; c < 21; c++) begin
      st = (c <= 9);
      if (c < 4)               tick_b(1'b0, 32'h40, 4'hF, 4'h0, 32'h0, st, r, d, e);
      else if (c < 6)          tick_b(1'b0, 32'h40, 4'h0, 4'hF, 32'h00000BAD, st, r, d, e);
      else if (c == 15)        tick_b(1'b0, 32'h40, 4'hF, 4'h0, 32'h0, st, r, d, e);
      else                     tick_b(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, st, r, d, e);
      er = (c >= 11 && c <= 14) || (c == 19);
      ed = er ? 32'h0000600D : 32'h0;
      ee = (c >= 5);
      checks++;
      if (r !== er || d !== ed || e !== ee) begin
        failures++;
        $display("FAIL full c=%0d resp=%b rdata=%h err=%b exp resp=%b rdata=%h err=%b",
                 c, r, d, e, er, ed, ee);
      end
    end
    tick_b(1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
    tick_b(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
    tick_b(1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b0, r, d, e);
    checks++;
    if (e !== 1'b0) begin
      failures++;
      $display("FAIL full_err_clear err=%b exp 0", e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bytemask();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_midburst();
    test_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- In-order memory-side responder for dmem_itf: the endpoint that a dmem_itf master (core LSQ or store buffer) talks to.
- Services word-addressed, byte-masked reads and writes from an internal word array.
- Returns one resp pulse per request after a programmable fixed latency. A response-stall input adds backpressure.
- Serves as the data-memory model behind the store buffer in block- and core-level benches, and as a scratchpad in small configs.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, minimum cycles from request to resp; legal range 1..8.
- DEPTH, 8, outstanding-request queue entries; power of two, >= LATENCY.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- slv_itf  dmem_itf.slv  -  responder side of dmem_itf; fields listed below
  - addr  in  32  byte address
  - rmask  in  4  byte read mask
  - wmask  in  4  byte write mask
  - wdata  in  32  write data
  - rdata  out  32  read data
  - resp  out  1  response pulse
- stall_i  in  1  blocks response issue for the following cycle
- err_o  out  1  sticky error flag: overflow or illegal request

Behaviour:
- Request:
  - A request is any cycle with |rmask or |wmask. Every such cycle is a new request.
  - A master may issue back-to-back requests, up to one per cycle.
- Index: word index = addr[$clog2(MEM_WORDS)+1:2]. addr[1:0] and upper bits are ignored, so out-of-range addresses wrap.
- Write accepted in cycle n:
  - Bytes with wmask[i]=1 update at the end of cycle n.
  - A read accepted in cycle n+1 sees the new data.
- Read accepted in cycle n:
  - Array data is sampled at the end of cycle n and stored in the queue entry.
  - Bytes with rmask[i]=0 are returned as 0x00.
  - Write responses carry rdata=0.
- Both masks nonzero in the same cycle:
  - Illegal; err_o set.
  - Treated as a write only; one response returned with rdata=0.
- Queue:
  - DEPTH-entry circular FIFO with wptr, rptr and count of PTR_W+1 bits; pointers wrap modulo DEPTH.
  - Each entry holds rdata and an age counter, saturating at LATENCY.
- Eligibility: the head entry accepted in cycle n is eligible for cycle c when c >= n+LATENCY.
- Issue rule:
  - resp=1 in cycle c iff the queue is non-empty, the head is eligible in c, and stall_i==0 in cycle c-1.
  - The head pops at the end of cycle c.
  - At most one resp per cycle; strictly in order.
  - rdata is valid only while resp=1 and is 0 otherwise.
- Full queue:
  - If count==DEPTH and a request arrives in a cycle with no pop, the request is dropped: no array update, no response, err_o set.
  - Push and pop in the same cycle at full is legal; count is unchanged.
- Empty queue: resp=0. With no stall and an empty queue, throughput is one response per cycle at latency exactly LATENCY.
- Stall: stalled cycles delay responses only. Requests keep being accepted and aged. After stall_i drops, queued eligible responses issue back-to-back.
- Reset (synchronous, rst high at a rising edge):
  - resp=0, rdata=0, err_o=0.
  - Queue emptied (wptr=rptr=count=0); pending responses are discarded, including on reset mid-burst.
  - Array contents are retained and not reset.
  - A request present in the same cycle as rst is ignored.
- err_o clears only on reset.

Test Plan:
- LATENCY=2: write addr 0x10, wmask 0xF, wdata 0xDEADBEEF in cycle 0 -> resp=1, rdata=0 in cycle 2. Read addr 0x10, rmask 0xF in cycle 3 -> resp in cycle 5 with rdata 0xDEADBEEF.
- Byte masks: write 0x11223344 wmask 0xF, then wdata 0xAABBCCDD wmask 0x2, then read rmask 0x6 -> rdata 0x0022CC00.
- Eight back-to-back reads with stall_i=0 -> eight consecutive resp cycles starting at cycle LATENCY, with rdata in issue order.
- stall_i high for cycles 1..5 with requests in cycles 0..3 -> no resp in cycles 2..6. Then four consecutive resps in cycles 7..10, in order, with no drops.
- DEPTH=4, LATENCY=4, stall held high, six requests -> first four receive responses after the stall releases, last two are dropped, err_o=1 from the fifth-request cycle+1 until reset.
- Reset mid-burst with three entries queued -> resp=0 the next cycle, no further resp, err_o=0. A subsequent read of a previously written address returns the retained data.
